// File: rtl/sd_bitstream_modulator.sv
// -----------------------------------------------------------------------------
// sd_bitstream_modulator
//
// Transmit-side first-order sigma-delta modulator. It takes 8-bit unsigned PCM
// samples at the low sample rate and turns them into a 1-bit pulse-density
// bitstream at the CLK rate. One sample is taken from a small input FIFO every
// OSR clocks.
//
// Parameters
//   OSR        - clocks per input sample (power of two, 2..256)
//   FIFO_DEPTH - input FIFO entries (power of two, 2..16)
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   asynchronous active-low reset
//   IN_DATA   in   [7:0] unsigned PCM sample
//   IN_VALID  in   IN_DATA valid; a push happens when IN_VALID && IN_READY
//   IN_READY  out  FIFO not full (decoded from the registered FIFO count)
//   OUT       out  registered pulse-density bitstream
//   UNDERRUN  out  one-cycle pulse after a sample fetch that found the FIFO empty
//
// Build option
//   SD_MOD_INTERP_EN - when defined, the modulator input is linearly
//   interpolated between the previous and the current sample across the
//   sample period. When undefined, the current sample is held (zero-order
//   hold). The previous-sample register exists only in interpolating builds
//   because nothing else reads it.
// -----------------------------------------------------------------------------
module sd_bitstream_modulator #(
    parameter int OSR        = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic       OUT,
    output logic       UNDERRUN
);

    localparam int            PW         = $clog2(OSR);
    localparam int            AW         = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PHASE_LAST = PW'(OSR - 1);
    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

    logic [PW-1:0] phase_r;
    logic [7:0]    acc_r;
    logic [7:0]    cur_r;
    logic          out_r;
    logic          underrun_r;

    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;

    logic          fetch_s;
    logic          fifo_empty_s;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    x_s;
    logic [8:0]    sum_s;

    assign fetch_s      = (phase_r == PHASE_LAST);
    assign fifo_empty_s = (count_r == (AW + 1)'(0));
    assign IN_READY     = (count_r != COUNT_FULL);
    assign push_s       = IN_VALID && IN_READY;
    // The fetch looks at the count before this cycle's push, so a sample
    // written on the fetch edge into an empty FIFO waits for the next wrap.
    assign pop_s        = fetch_s && !fifo_empty_s;

`ifdef SD_MOD_INTERP_EN
    logic [7:0]         prev_r;
    logic signed [19:0] diff_s;
    logic signed [19:0] phase_sx_s;
    logic signed [19:0] prod_s;
    logic signed [19:0] step_s;

    assign diff_s     = $signed({12'd0, cur_r}) - $signed({12'd0, prev_r});
    assign phase_sx_s = $signed(20'(phase_r));
    assign prod_s     = diff_s * phase_sx_s;
    // Arithmetic shift gives floor division for negative slopes as well.
    assign step_s     = prod_s >>> PW;

    // Interpolated modulator input; prev + floor(diff*phase/OSR) stays in 0..255.
    always_comb begin
        x_s = 8'($signed({12'd0, prev_r}) + step_s);
    end

    // Previous-sample register, shifted at every fetch edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_r <= 8'd0;
        end else if (fetch_s) begin
            prev_r <= cur_r;
        end
    end
`else
    // Zero-order hold: the current sample drives the modulator all period long.
    always_comb begin
        x_s = cur_r;
    end
`endif

    assign sum_s = {1'b0, acc_r} + {1'b0, x_s};

    // Sample-period phase counter; OSR is a power of two so it wraps naturally.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            phase_r <= {PW{1'b0}};
        end else begin
            phase_r <= phase_r + PW'(1);
        end
    end

    // First-order modulator: the carry out of the accumulator is the output bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_r <= 8'd0;
            out_r <= 1'b0;
        end else begin
            acc_r <= sum_s[7:0];
            out_r <= sum_s[8];
        end
    end

    // Current sample and underrun flag, both updated at the fetch edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cur_r      <= 8'd0;
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= fetch_s && fifo_empty_s;
            if (pop_s) begin
                cur_r <= fifo_mem_r[rd_ptr_r];
            end
        end
    end

    // FIFO storage and write pointer.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'd0;
            end
            wr_ptr_r <= {AW{1'b0}};
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= IN_DATA;
            wr_ptr_r             <= wr_ptr_r + AW'(1);
        end
    end

    // FIFO read pointer and occupancy count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= (AW + 1)'(0);
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign OUT      = out_r;
    assign UNDERRUN = underrun_r;

endmodule

// File: tb/tb_sd_bitstream_modulator.sv
// -----------------------------------------------------------------------------
// Testbench for sd_bitstream_modulator (OSR=64, FIFO_DEPTH=4).
// A cycle-level reference model holds the FIFO as a queue and computes the
// modulator input and output bit with plain integer arithmetic. Directed
// phases (idle, constant streams, FIFO fill, reset mid-stream) are mixed with
// randomized traffic. Follows SD_MOD_INTERP_EN like the design.
// -----------------------------------------------------------------------------
module tb_sd_bitstream_modulator;

    localparam int OSR   = 64;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] IN_DATA;
    logic       IN_VALID;
    logic       IN_READY;
    logic       OUT;
    logic       UNDERRUN;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_phase, m_acc, m_prev, m_cur, m_out, m_und;
    int m_q[$];

    int ones;
    int und_seen;

    sd_bitstream_modulator #(.OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .OUT      (OUT),
        .UNDERRUN (UNDERRUN)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic void model_reset();
        m_phase = 0;
        m_acc   = 0;
        m_prev  = 0;
        m_cur   = 0;
        m_out   = 0;
        m_und   = 0;
        m_q.delete();
    endfunction

    function automatic int model_x();
`ifdef SD_MOD_INTERP_EN
        int num;
        int q;
        num = (m_cur - m_prev) * m_phase;
        if (num >= 0) q = num / OSR;
        else          q = -((-num + OSR - 1) / OSR);
        return m_prev + q;
`else
        return m_cur;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model, check after the rising edge.
    task automatic step(input bit v, input logic [7:0] d, output bit accepted);
        int  x;
        int  s;
        bit  ready;
        @(negedge CLK);
        IN_VALID = v;
        IN_DATA  = d;
        ready = (m_q.size() < DEPTH);
        #1;
        check("in_ready", {31'd0, IN_READY}, {31'd0, ready});
        x     = model_x();
        s     = m_acc + x;
        m_out = (s >= 256) ? 1 : 0;
        m_acc = s % 256;
        m_und = 0;
        if (m_phase == OSR - 1) begin
            m_prev = m_cur;
            if (m_q.size() > 0) m_cur = m_q.pop_front();
            else                m_und = 1;
        end
        accepted = v && ready;
        if (accepted) m_q.push_back(int'(d));
        m_phase = (m_phase + 1) % OSR;
        @(posedge CLK);
        #1;
        check("out", {31'd0, OUT}, 32'(m_out));
        check("underrun", {31'd0, UNDERRUN}, 32'(m_und));
        ones     += (OUT === 1'b1) ? 1 : 0;
        und_seen += (UNDERRUN === 1'b1) ? 1 : 0;
    endtask

    // Assert reset now, check the asynchronous clear, release just after the next rising edge.
    task automatic do_reset();
        IN_VALID = 1'b0;
        RST      = 1'b0;
        #1;
        check("rst_out", {31'd0, OUT}, 32'd0);
        check("rst_underrun", {31'd0, UNDERRUN}, 32'd0);
        check("rst_ready", {31'd0, IN_READY}, 32'd1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        model_reset();
    endtask

    initial begin
        bit         a;
        int         idx;
        logic [7:0] samp [6];
        samp = '{8'h10, 8'h70, 8'hA0, 8'h30, 8'hE0, 8'h55};

        RST      = 1'b0;
        IN_VALID = 1'b0;
        IN_DATA  = 8'h00;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        do_reset();

        // idle after reset: underrun every OSR cycles, output stays low
        ones = 0;
        und_seen = 0;
        repeat (300) step(1'b0, 8'h00, a);
        check("idle_underruns", 32'(und_seen), 32'd4);
        check("idle_ones", 32'(ones), 32'd0);

        // constant mid-scale stream
        repeat (6 * OSR) step(1'b1, 8'h80, a);
        ones = 0;
        und_seen = 0;
        repeat (64) step(1'b1, 8'h80, a);
        check("half_scale_ones_64", 32'(ones), 32'd32);
        check("half_scale_no_underrun", 32'(und_seen), 32'd0);

        // full scale then zero
        repeat (7 * OSR) step(1'b1, 8'hFF, a);
        ones = 0;
        repeat (256) step(1'b1, 8'hFF, a);
        check("full_scale_ones_256", 32'(ones), 32'd255);
        repeat (7 * OSR) step(1'b1, 8'h00, a);
        ones = 0;
        repeat (256) step(1'b1, 8'h00, a);
        check("zero_ones_256", 32'(ones), 32'd0);

        // fill the FIFO from reset with six distinct samples held valid
        do_reset();
        idx = 0;
        repeat (10) begin
            step(idx < 6, (idx < 6) ? samp[idx] : 8'h00, a);
            if (a) idx++;
        end
        check("accepted_before_fetch", 32'(idx), 32'd4);
        repeat (6 * OSR) begin
            step(idx < 6, (idx < 6) ? samp[idx] : 8'h00, a);
            if (a) idx++;
        end
        check("accepted_total", 32'(idx), 32'd6);

        // randomized traffic, dense then sparse (sparse provokes underruns)
        repeat (1500) step($urandom_range(0, 3) != 0, 8'($urandom), a);
        repeat (800) step($urandom_range(0, 99) < 2, 8'($urandom), a);

        // reset mid-period with three samples queued
        do_reset();
        step(1'b1, 8'hC0, a);
        repeat (70) step(1'b0, 8'h00, a);
        repeat (3) step(1'b1, 8'($urandom_range(1, 255)), a);
        check("queued_before_reset", 32'(m_q.size()), 32'd3);
        for (int k = 0; k < 8 && OUT !== 1'b1; k++) step(1'b0, 8'h00, a);
        check("pre_reset_out_high", {31'd0, OUT}, 32'd1);
        #2;
        do_reset();
        ones = 0;
        und_seen = 0;
        repeat (140) step(1'b0, 8'h00, a);
        check("post_reset_underruns", 32'(und_seen), 32'd2);
        check("post_reset_ones", 32'(ones), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
